// File: rtl/seven_segment_scan_display_if.sv
// Signal bundle between the CPU status tap (master) and the multiplexed
// seven-segment scanner (slave).
interface seven_segment_scan_display_if #(
    parameter int DIGITS = 4
);
    // load has no ready: every cycle load is high, value is captured.
    // pending stays high until that capture has been committed to the display.
    logic                  ena;
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic                  blank_lz;
    logic [DIGITS-1:0]     dp_mask;
    logic [6:0]            seg;
    logic                  dp;
    logic [DIGITS-1:0]     dig_sel;
    logic                  pending;
    logic                  frame_done;

    modport master (
        output ena, load, value, blank_lz, dp_mask,
        input  seg, dp, dig_sel, pending, frame_done
    );

    modport slave (
        input  ena, load, value, blank_lz, dp_mask,
        output seg, dp, dig_sel, pending, frame_done
    );
endinterface

// File: rtl/seven_segment_scan_display.sv
// Time-multiplexed hex display driver: captures a multi-nibble value, commits
// it only at frame boundaries, and scans it across the digits with blanking.
module seven_segment_scan_display #(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 1000,
    parameter int BLANK_CYCLES   = 16,
    parameter int ACTIVE_LOW_SEG = 0,
    parameter int ACTIVE_LOW_DIG = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    seven_segment_scan_display_if.slave  bus
);
    localparam int C_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int D_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int V_W = 4 * DIGITS;

    localparam logic [C_W-1:0]    C_LAST  = C_W'(SCAN_DIV - 1);
    localparam logic [C_W-1:0]    C_LIT   = C_W'(BLANK_CYCLES);
    localparam logic [D_W-1:0]    D_LAST  = D_W'(DIGITS - 1);
    localparam logic [6:0]        SEG_INV = (ACTIVE_LOW_SEG != 0) ? 7'h7F : 7'h00;
    localparam logic              DP_INV  = (ACTIVE_LOW_SEG != 0);
    localparam logic [DIGITS-1:0] DIG_INV = (ACTIVE_LOW_DIG != 0) ? {DIGITS{1'b1}} : '0;

    logic [C_W-1:0]    c_q;
    logic [D_W-1:0]    d_q;
    logic [V_W-1:0]    shadow_q;
    logic [V_W-1:0]    disp_q;
    logic              pending_q;
    logic              frame_done_q;
    logic [6:0]        seg_q;
    logic              dp_q;
    logic [DIGITS-1:0] dig_q;

    logic              slot_end;
    logic              boundary;
    logic [C_W-1:0]    c_next;
    logic [D_W-1:0]    d_next;
    logic [3:0]        cur_nib;
    logic [DIGITS-1:0] lz_blank;
    logic              lz_run;
    logic [6:0]        seg_n;
    logic              dp_n;
    logic [DIGITS-1:0] dig_n;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Scan position; a frozen position simply holds while ena is low.
    always_comb begin
        slot_end = bus.ena && (c_q == C_LAST);
        boundary = slot_end && (d_q == D_LAST);
        c_next   = c_q;
        d_next   = d_q;
        if (bus.ena) begin
            if (slot_end) begin
                c_next = '0;
                d_next = boundary ? '0 : d_q + 1'b1;
            end else begin
                c_next = c_q + 1'b1;
            end
        end
    end

    // A digit is suppressed when it and every more significant nibble are zero.
    always_comb begin
        lz_blank = '0;
        lz_run   = bus.blank_lz;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lz_run      = lz_run && (disp_q[4*i +: 4] == 4'h0);
            lz_blank[i] = lz_run;
        end
    end

    always_comb begin
        cur_nib = disp_q[d_q*4 +: 4];
        seg_n   = 7'h00;
        dp_n    = 1'b0;
        dig_n   = '0;
        if (bus.ena && (c_q >= C_LIT)) begin
            dig_n[d_q] = 1'b1;
            seg_n      = lz_blank[d_q] ? 7'h00 : hex_to_seg(cur_nib);
            dp_n       = bus.dp_mask[d_q];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_q          <= '0;
            d_q          <= '0;
            shadow_q     <= '0;
            disp_q       <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            seg_q        <= SEG_INV;
            dp_q         <= DP_INV;
            dig_q        <= DIG_INV;
        end else begin
            c_q          <= c_next;
            d_q          <= d_next;
            frame_done_q <= boundary;
            if (bus.load) begin
                shadow_q <= bus.value;
            end
            // A load landing on the boundary edge bypasses the shadow stage.
            if (boundary && bus.load) begin
                disp_q <= bus.value;
            end else if (boundary && pending_q) begin
                disp_q <= shadow_q;
            end
            if (boundary) begin
                pending_q <= 1'b0;
            end else if (bus.load) begin
                pending_q <= 1'b1;
            end
            seg_q <= seg_n ^ SEG_INV;
            dp_q  <= dp_n ^ DP_INV;
            dig_q <= dig_n ^ DIG_INV;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.dig_sel    = dig_q;
    assign bus.pending    = pending_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_segment_scan_display.sv
// Directed bench for the scan display: an active-high instance (a) and an
// active-low instance (b) run side by side against expected-value queues.
module tb_seven_segment_scan_display;
    logic clk;
    logic rst_n;

    int total = 0;
    int bad   = 0;
    int ka    = 0;
    int kb    = 0;

    logic [7:0] exp_q[$];
    logic [6:0] a_tab [4];
    logic [6:0] b_tab [4];

    seven_segment_scan_display_if #(.DIGITS(4)) a_if ();
    seven_segment_scan_display_if #(.DIGITS(4)) b_if ();

    seven_segment_scan_display #(
        .DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2),
        .ACTIVE_LOW_SEG(0), .ACTIVE_LOW_DIG(0)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if.slave)
    );

    seven_segment_scan_display #(
        .DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2),
        .ACTIVE_LOW_SEG(1), .ACTIVE_LOW_DIG(1)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // scoreboard
    task automatic chk(input string tag, input logic [7:0] obs);
        logic [7:0] exp;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s: observed %02h, no expected value queued", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                bad++;
                $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
            end
        end
    endtask

    task automatic expect_now(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        exp_q.push_back(exp);
        chk(tag, obs);
    endtask

    task automatic set_a(input logic [6:0] t3, t2, t1, t0);
        a_tab[3] = t3; a_tab[2] = t2; a_tab[1] = t1; a_tab[0] = t0;
    endtask

    task automatic set_b(input logic [6:0] t3, t2, t1, t0);
        b_tab[3] = t3; b_tab[2] = t2; b_tab[1] = t1; b_tab[0] = t0;
    endtask

    // One clock: queue what each instance must show for the current scan
    // position, advance, then compare on the falling edge.
    task automatic tick();
        int ca, da, cb, db;
        logic la, lb;
        ca = ka % 8;
        da = (ka / 8) % 4;
        cb = kb % 8;
        db = (kb / 8) % 4;
        la = rst_n && a_if.ena && (ca >= 2);
        lb = rst_n && b_if.ena && (cb >= 2);
        exp_q.push_back(la ? {1'b0, a_tab[da]} : 8'h00);
        exp_q.push_back(la ? 8'(1 << da) : 8'h00);
        exp_q.push_back(la ? {7'd0, a_if.dp_mask[da]} : 8'h00);
        exp_q.push_back({7'd0, rst_n && a_if.ena && (ka % 32 == 31)});
        exp_q.push_back({1'b0, ~(lb ? b_tab[db] : 7'h00)});
        exp_q.push_back({4'h0, ~(lb ? 4'(1 << db) : 4'h0)});
        exp_q.push_back({7'd0, ~(lb ? b_if.dp_mask[db] : 1'b0)});
        if (rst_n && a_if.ena) ka++;
        if (rst_n && b_if.ena) kb++;
        @(posedge clk);
        @(negedge clk);
        chk("a_seg", {1'b0, a_if.seg});
        chk("a_dig_sel", {4'h0, a_if.dig_sel});
        chk("a_dp", {7'd0, a_if.dp});
        chk("a_frame_done", {7'd0, a_if.frame_done});
        chk("b_seg", {1'b0, b_if.seg});
        chk("b_dig_sel", {4'h0, b_if.dig_sel});
        chk("b_dp", {7'd0, b_if.dp});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance instance a to the first position of the next frame.
    task automatic run_to_frame();
        for (int i = 0; i < 32 && (ka % 32 != 0); i++) tick();
    endtask

    // directed steps
    initial begin
        rst_n = 1'b0;
        a_if.ena = 1'b1; a_if.load = 1'b1; a_if.value = 16'h1234;
        a_if.blank_lz = 1'b0; a_if.dp_mask = 4'b0000;
        b_if.ena = 1'b1; b_if.load = 1'b1; b_if.value = 16'h8888;
        b_if.blank_lz = 1'b0; b_if.dp_mask = 4'b0001;
        set_a(7'h3F, 7'h3F, 7'h3F, 7'h3F);
        set_b(7'h3F, 7'h3F, 7'h3F, 7'h3F);

        // reset held with ena and load high
        run(3);
        expect_now("a_pending_rst", {7'd0, a_if.pending}, 8'h00);
        expect_now("b_pending_rst", {7'd0, b_if.pending}, 8'h00);
        rst_n = 1'b1;
        a_if.load = 1'b0;
        b_if.load = 1'b0;
        ka = 0;
        kb = 0;

        // first lit cycle is the third after release
        run(3);

        // hex scan of 0x12AF; b gets an 8 on digit 0
        a_if.value = 16'h12AF; a_if.load = 1'b1;
        b_if.value = 16'h0008; b_if.load = 1'b1;
        tick();
        a_if.load = 1'b0; b_if.load = 1'b0;
        expect_now("a_pending_load", {7'd0, a_if.pending}, 8'h01);
        expect_now("b_pending_load", {7'd0, b_if.pending}, 8'h01);
        run_to_frame();
        expect_now("a_pending_commit", {7'd0, a_if.pending}, 8'h00);
        expect_now("b_pending_commit", {7'd0, b_if.pending}, 8'h00);
        set_a(7'h06, 7'h5B, 7'h77, 7'h71);
        set_b(7'h3F, 7'h3F, 7'h3F, 7'h7F);
        run(32);

        // leading-zero suppression, dp still shown on blanked digit 2
        a_if.value = 16'h0050; a_if.load = 1'b1;
        a_if.blank_lz = 1'b1; a_if.dp_mask = 4'b0101;
        tick();
        a_if.load = 1'b0;
        run_to_frame();
        set_a(7'h00, 7'h00, 7'h6D, 7'h3F);
        run(32);
        a_if.value = 16'h0000; a_if.load = 1'b1;
        tick();
        a_if.load = 1'b0;
        run_to_frame();
        set_a(7'h00, 7'h00, 7'h00, 7'h3F);
        run(32);

        // tear-free commit: two loads inside one frame
        a_if.value = 16'h1111; a_if.load = 1'b1;
        tick();
        a_if.load = 1'b0;
        run(5);
        a_if.value = 16'h2222; a_if.load = 1'b1;
        tick();
        a_if.load = 1'b0;
        expect_now("a_pending_mid", {7'd0, a_if.pending}, 8'h01);
        run_to_frame();
        expect_now("a_pending_tear", {7'd0, a_if.pending}, 8'h00);
        a_if.blank_lz = 1'b0;
        set_a(7'h5B, 7'h5B, 7'h5B, 7'h5B);
        run(32);

        // load exactly on the boundary edge
        run(31);
        a_if.value = 16'h3333; a_if.load = 1'b1;
        tick();
        a_if.load = 1'b0;
        expect_now("a_pending_edge", {7'd0, a_if.pending}, 8'h00);
        set_a(7'h4F, 7'h4F, 7'h4F, 7'h4F);
        run(32);

        // enable gating at c=5, d=2 for ten cycles with a load
        run(21);
        a_if.ena = 1'b0;
        a_if.value = 16'h0007; a_if.load = 1'b1;
        tick();
        a_if.load = 1'b0;
        run(9);
        expect_now("a_pending_gated", {7'd0, a_if.pending}, 8'h01);
        a_if.ena = 1'b1;
        run_to_frame();
        expect_now("a_pending_resume", {7'd0, a_if.pending}, 8'h00);
        set_a(7'h3F, 7'h3F, 7'h3F, 7'h07);
        run(32);

        // reset mid-frame discards a pending capture
        run(10);
        a_if.value = 16'h5555; a_if.load = 1'b1;
        b_if.value = 16'h5555; b_if.load = 1'b1;
        tick();
        a_if.load = 1'b0; b_if.load = 1'b0;
        expect_now("a_pending_prerst", {7'd0, a_if.pending}, 8'h01);
        rst_n = 1'b0;
        tick();
        expect_now("a_pending_midrst", {7'd0, a_if.pending}, 8'h00);
        expect_now("b_pending_midrst", {7'd0, b_if.pending}, 8'h00);
        rst_n = 1'b1;
        ka = 0;
        kb = 0;
        set_a(7'h3F, 7'h3F, 7'h3F, 7'h3F);
        set_b(7'h3F, 7'h3F, 7'h3F, 7'h3F);
        run(64);
        expect_now("a_pending_final", {7'd0, a_if.pending}, 8'h00);
        expect_now("queue_drained", 8'(exp_q.size()), 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seven_segment_scan_display.md
# seven_segment_scan_display

Time-multiplexed multi-digit seven-segment driver that replaces the single-nibble combinational hex decoder on the CPU status output. It captures a `4*DIGITS`-bit value from the CPU side and scans it across `DIGITS` common-cathode or common-anode digits, one digit per slot. It adds tear-free frame-boundary commit, anti-ghosting blanking, leading-zero suppression and per-digit decimal points. It sits between the data-memory status tap and the `uo_out`/`uio_out` pads of the top-level wrapper.

## Interface
- `DIGITS`, 4: number of digits scanned, 1..8.
- `SCAN_DIV`, 1000: clock cycles per digit slot, at least 2.
- `BLANK_CYCLES`, 16: cycles at the start of each slot with all digits off; must be less than `SCAN_DIV`.
- `ACTIVE_LOW_SEG`, 0: 1 inverts `seg` and `dp`.
- `ACTIVE_LOW_DIG`, 0: 1 inverts `dig_sel`.

Ports:
- `clk` in 1: single clock; everything is on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `ena` in 1: scan enable.
- `load` in 1: capture request for `value`, single-cycle or held.
- `value` in `4*DIGITS`: nibble i is shown on digit i; digit 0 is rightmost.
- `blank_lz` in 1: enables leading-zero suppression.
- `dp_mask` in `DIGITS`: bit i lights the decimal point on digit i; sampled live.
- `seg` out 7: segments {g,f,e,d,c,b,a}, with a at bit 0; registered.
- `dp` out 1: decimal point; registered.
- `dig_sel` out `DIGITS`: one-hot digit enable; registered.
- `pending` out 1: a captured value is waiting for commit.
- `frame_done` out 1: one-cycle pulse at each frame wrap.

## Operation
- **State**
  - `shadow` and `disp` registers, each `4*DIGITS` wide.
  - Slot counter `c`, range 0..`SCAN_DIV`-1, width `$clog2(SCAN_DIV)`.
  - Digit index `d`, range 0..`DIGITS`-1.
- **Scan.** With `ena`=1, `c` increments each cycle.
  - When `c`=`SCAN_DIV`-1, `c` goes to 0 and `d` advances.
  - `d` wraps from `DIGITS`-1 to 0. That wrap edge is the frame boundary.
- **Capture.** `load`=1 writes `value` into `shadow` and sets `pending`.
- **Commit.** At a frame boundary with `pending`=1, `shadow` moves to `disp` and `pending` clears.
- **Load at the boundary.** If `load`=1 on the boundary edge itself, `value` goes directly to `disp`, and `shadow` is also written. `pending` ends at 0.
- **Held load.** A `load` held high re-captures every cycle. The commit rule above still applies.
- **Decode.** Standard hex map, before polarity inversion:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- **Leading-zero suppression.** With `blank_lz`=1, digit i (i ≥ 1) is blank if `disp` nibbles `DIGITS`-1 down to i are all zero.
  - Digit 0 is never blanked.
  - A blanked digit drives `seg`=0, but `dig_sel` and `dp` still follow normal rules.
- **Output, ena=1.**
  - If `c` < `BLANK_CYCLES`: `dig_sel`=0 and `seg`=0.
  - Otherwise: `dig_sel` is one-hot at `d`, `seg` is the decode of nibble `d`, and `dp` = `dp_mask[d]`.
- **Output, ena=0.**
  - `c` and `d` freeze, and `dig_sel`, `seg` and `dp` are all off.
  - `load` is still accepted, and no commit occurs.
  - When `ena` returns to 1, the scan resumes from the frozen `c`/`d`.
- **Polarity.** Inversion is applied to the final registered outputs. "Off" means the inactive level.

## Timing
- **Reset** (`rst_n`=0 at an edge): `c`=0, `d`=0, `disp`=`shadow`=0, `pending`=0, `frame_done`=0.
  - `seg`, `dp` and `dig_sel` go to their inactive levels: 0, or all-ones when inverted.
  - Reset applied mid-frame aborts the scan immediately; a pending value is discarded.
- **Output latency.** `seg`, `dp` and `dig_sel` reflect (`c`,`d`,`disp`) one cycle later.
  - After reset release, the first lit cycle is cycle `BLANK_CYCLES`+1.
- **frame_done.** High for exactly one cycle, in the cycle after the boundary edge. Period is `DIGITS*SCAN_DIV` cycles while `ena`=1.
- **pending.** Registered, and high in the cycle after `load`.
- **Commit latency.** A new value first appears in the slot for digit 0 following the next boundary. Worst case is `DIGITS*SCAN_DIV`+1 cycles.
- **dp_mask.** Takes effect with one cycle of latency.

## Test plan
Benches use `DIGITS`=4, `SCAN_DIV`=8, `BLANK_CYCLES`=2 unless noted.
- **Reset:** hold `rst_n`=0 for 3 cycles with `ena`=1 and `load`=1 → `seg`=00, `dp`=0, `dig_sel`=0, `pending`=0, `frame_done`=0; first `dig_sel`=0001 at cycle 3 after release.
- **Hex scan:** load 0x12AF, `blank_lz`=0, then wait one frame → `dig_sel` 0001/0010/0100/1000 with `seg` 71/77/5B/06 respectively, each lit 6 of 8 cycles; `frame_done` every 32 cycles.
- **Leading zeros:** `disp`=0x0050, `blank_lz`=1 → digits 3 and 2 show `seg`=00 with `dig_sel` still stepping; digit 1 shows 6D, digit 0 shows 3F; `disp`=0x0000 shows 3F on digit 0 only.
- **Tear-free commit:**
  - Load 0x1111 then 0x2222 mid-frame → `pending`=1 and the old value shows until the boundary; after it, 5B on all digits.
  - `load` 0x3333 exactly on the boundary edge → 4F appears with `pending`=0.
- **Enable gating:** drop `ena` at `c`=5, `d`=2 for 10 cycles while loading 0x0007 → `dig_sel`=0 and no commit; after resume, digit 2 finishes its remaining 3 cycles, then the boundary commits and digit 0 shows 07.
- **Polarity and decimal point:** `ACTIVE_LOW_SEG`=1, `ACTIVE_LOW_DIG`=1 → reset gives `seg`=7F, `dig_sel`=1111, `dp`=1; value 8 on digit 0 gives `seg`=00 and `dig_sel`=1110; `dp_mask`=0001 gives `dp`=0 on digit 0 only.
